// File: rtl/ultrasensor_multi_ctrl.sv
// Round-robin ultrasonic ranging controller: triggers one sensor per period and stores its echo width.
// Optional macro US_AVG2_EN: stored widths become the running average of the previous and latest sample.
module ultrasensor_multi_ctrl #(
  parameter int N_CH          = 4,
  parameter int CNT_W         = 23,
  parameter int TRIG_CYCLES   = 1000,
  parameter int MAX_CYCLES    = 1156852,
  parameter int PERIOD_CYCLES = 6000000,
  localparam int AW           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  control,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH-1:0]       echo,
  output logic [N_CH-1:0]       trigger,
  output logic [N_CH*CNT_W-1:0] s_echo,
  output logic [N_CH-1:0]       s_valid,
  output logic [N_CH-1:0]       timeout,
  output logic [AW-1:0]         active_ch
);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);

  state_t                       state;
  logic [N_CH-1:0]              echo_meta;
  logic [N_CH-1:0]              echo_sync;
  logic [CNT_W-1:0]             cnt;
  logic [CNT_W-1:0]             pcnt;
  logic [N_CH-1:0][CNT_W-1:0]   echo_r;
  logic [CNT_W-1:0]             meas_val;
  logic [AW-1:0]                next_ch;
  logic                         echo_now;

  // First enabled channel found scanning upward from cur+first, wrapping at N_CH.
  function automatic logic [AW-1:0] pick(input logic [AW-1:0] cur, input int unsigned first,
                                         input logic [N_CH-1:0] mask);
    int unsigned     idx;
    logic [N_CH-1:0] sh;
    pick = cur;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = (32'(cur) + first + N_CH - 1 - i) % N_CH;
      sh  = mask >> idx;
      if (sh[0]) pick = idx[AW-1:0];
    end
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_meta <= '0;
      echo_sync <= '0;
    end else begin
      echo_meta <= echo;
      echo_sync <= echo_meta;
    end
  end

  assign echo_now = echo_sync[active_ch];
  assign next_ch  = pick(active_ch, (state == HOLDOFF) ? 1 : 0, ch_en);
  assign s_echo   = echo_r;

`ifdef US_AVG2_EN
  logic [N_CH-1:0] hist;
  logic [CNT_W:0]  sum;
  always_comb begin
    sum      = {1'b0, echo_r[active_ch]} + {1'b0, cnt};
    meas_val = hist[active_ch] ? sum[CNT_W:1] : cnt;
  end
`else
  assign meas_val = cnt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      trigger   <= '0;
      echo_r    <= '0;
      s_valid   <= '0;
      timeout   <= '0;
      active_ch <= '0;
      cnt       <= '0;
      pcnt      <= '0;
`ifdef US_AVG2_EN
      hist      <= '0;
`endif
    end else begin
      s_valid <= '0;
      if (!control) begin
        state   <= IDLE;
        trigger <= '0;
        cnt     <= '0;
        pcnt    <= '0;
      end else begin
        // Period counter runs from trigger rise and saturates rather than wrapping.
        if (state != IDLE && pcnt != '1) pcnt <= pcnt + 1'b1;
        case (state)
          IDLE: begin
            if (|ch_en) begin
              active_ch <= next_ch;
              trigger   <= N_CH'(1) << next_ch;
              cnt       <= '0;
              pcnt      <= '0;
              state     <= TRIG;
            end
          end
          TRIG: begin
            if (cnt == TRIG_LAST) begin
              trigger <= '0;
              cnt     <= '0;
              state   <= WAIT_RISE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_RISE: begin
            if (echo_now) begin
              // The rising cycle is itself one cycle of echo width.
              cnt   <= CNT_W'(1);
              state <= MEASURE;
            end else if (cnt >= MAX_C - 1'b1) begin
              echo_r[active_ch]  <= MAX_C;
              timeout[active_ch] <= 1'b1;
              s_valid[active_ch] <= 1'b1;
`ifdef US_AVG2_EN
              hist[active_ch]    <= 1'b0;
`endif
              state <= HOLDOFF;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          MEASURE: begin
            if (!echo_now) begin
              echo_r[active_ch]  <= meas_val;
              timeout[active_ch] <= 1'b0;
              s_valid[active_ch] <= 1'b1;
`ifdef US_AVG2_EN
              hist[active_ch]    <= 1'b1;
`endif
              state <= HOLDOFF;
            end else if (cnt >= MAX_C) begin
              echo_r[active_ch]  <= MAX_C;
              timeout[active_ch] <= 1'b1;
              s_valid[active_ch] <= 1'b1;
`ifdef US_AVG2_EN
              hist[active_ch]    <= 1'b0;
`endif
              state <= HOLDOFF;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HOLDOFF: begin
            if (pcnt >= PER_LAST) begin
              if (|ch_en) begin
                active_ch <= next_ch;
                trigger   <= N_CH'(1) << next_ch;
                cnt       <= '0;
                pcnt      <= '0;
                state     <= TRIG;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ultrasensor_multi_ctrl.sv
// Directed bench for ultrasensor_multi_ctrl with a scoreboard of expected stores; honours US_AVG2_EN.
module tb_ultrasensor_multi_ctrl;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TC = 10;
  localparam int MC = 300;
  localparam int PC = 1000;

  logic           clk = 1'b0;
  logic           reset;
  logic           control;
  logic [N-1:0]   ch_en;
  logic [N-1:0]   echo;
  logic [N-1:0]   trigger;
  logic [N*W-1:0] s_echo;
  logic [N-1:0]   s_valid;
  logic [N-1:0]   timeout;
  logic [1:0]     active_ch;

  ultrasensor_multi_ctrl #(
    .N_CH(N), .CNT_W(W), .TRIG_CYCLES(TC), .MAX_CYCLES(MC), .PERIOD_CYCLES(PC)
  ) dut (
    .clk(clk), .reset(reset), .control(control), .ch_en(ch_en), .echo(echo),
    .trigger(trigger), .s_echo(s_echo), .s_valid(s_valid), .timeout(timeout),
    .active_ch(active_ch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int ch; int val; logic to;} exp_t;
  exp_t sb[$];
  int   last_val[N];
`ifdef US_AVG2_EN
  logic hist[N];
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input int raw, input logic to);
    int v;
    if (to) begin
      v = MC;
`ifdef US_AVG2_EN
      hist[ch] = 1'b0;
`endif
    end else begin
`ifdef US_AVG2_EN
      v = hist[ch] ? (last_val[ch] + raw) / 2 : raw;
      hist[ch] = 1'b1;
`else
      v = raw;
`endif
    end
    last_val[ch] = v;
    sb.push_back('{ch, v, to});
  endtask

  always @(negedge clk) begin
    if (s_valid !== '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_s_valid", 64'(s_valid), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("s_valid_onehot", 64'(s_valid), 64'(1) << e.ch);
        chk($sformatf("s_echo_ch%0d", e.ch), 64'(s_echo[e.ch*W +: W]), 64'(e.val));
        chk($sformatf("timeout_ch%0d", e.ch), 64'(timeout[e.ch]), 64'(e.to));
      end
    end
  end

  task automatic wait_trig(input int ch, output int rise_cyc, output bit ok);
    int n;
    n = 0;
    while (trigger === '0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    rise_cyc = cyc;
    chk($sformatf("trigger_select_ch%0d", ch), 64'(trigger), 64'(1) << ch);
    ok = (trigger !== '0);
  endtask

  task automatic wait_trig_fall(input int ch);
    int n;
    n = 0;
    while (trigger[ch] === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("trigger_width_ch%0d", ch), 64'(n), 64'(TC));
  endtask

  task automatic run_ch(input int ch, input int width, output int rise_cyc);
    bit ok;
    wait_trig(ch, rise_cyc, ok);
    if (ok) begin
      wait_trig_fall(ch);
      if (width == 0) begin
        push(ch, 0, 1'b1);
      end else begin
        repeat (20) @(posedge clk);
        #1 echo[ch] = 1'b1;
        repeat (width) @(posedge clk);
        #1 echo[ch] = 1'b0;
        push(ch, width, 1'b0);
      end
    end
  endtask

  initial begin
    int t0, t1, t2, t;
    bit ok;
    reset = 1'b1; control = 1'b0; ch_en = '0; echo = '0;
    for (int i = 0; i < N; i++) last_val[i] = 0;
`ifdef US_AVG2_EN
    for (int i = 0; i < N; i++) hist[i] = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_trigger", 64'(trigger), 64'(0));
    chk("reset_s_echo", 64'(s_echo), 64'(0));
    chk("reset_s_valid", 64'(s_valid), 64'(0));
    chk("reset_timeout", 64'(timeout), 64'(0));
    chk("reset_active_ch", 64'(active_ch), 64'(0));

    ch_en = 4'b1111; control = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    run_ch(0, 50, t0);
    run_ch(1, 0, t1);
    chk("period_ch0_to_ch1", 64'(t1 - t0), 64'(PC));
    run_ch(2, 80, t2);
    chk("period_after_timeout", 64'(t2 - t1), 64'(PC));
    run_ch(3, 120, t);
    run_ch(0, 70, t);

    ch_en = 4'b1010;
    for (int i = 0; i < 4; i++) run_ch((i % 2 == 0) ? 1 : 3, 30 + 10 * i, t);
    chk("skipped_s_echo_ch0", 64'(s_echo[0*W +: W]), 64'(last_val[0]));
    chk("skipped_s_echo_ch2", 64'(s_echo[2*W +: W]), 64'(last_val[2]));
    chk("skipped_timeout_ch0_ch2", 64'({timeout[2], timeout[0]}), 64'(0));

    // Abandon a measurement on channel 2 by dropping control mid-echo.
    ch_en = 4'b0100;
    wait_trig(2, t, ok);
    if (ok) wait_trig_fall(2);
    repeat (20) @(posedge clk);
    #1 echo[2] = 1'b1;
    repeat (30) @(posedge clk);
    #1 control = 1'b0;
    @(negedge clk);
    chk("drop_trigger", 64'(trigger), 64'(0));
    repeat (10) @(negedge clk);
    chk("drop_trigger_idle", 64'(trigger), 64'(0));
    chk("drop_s_echo_ch2", 64'(s_echo[2*W +: W]), 64'(last_val[2]));
    chk("drop_active_ch", 64'(active_ch), 64'(2));
    echo[2] = 1'b0;
    ch_en = 4'b1111;
    control = 1'b1;
    run_ch(2, 40, t);

    // Reset between clock edges while channel 3 is triggering.
    wait_trig(3, t, ok);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    #2 reset = 1'b1;
    #1;
    chk("async_reset_trigger", 64'(trigger), 64'(0));
    chk("async_reset_s_echo", 64'(s_echo), 64'(0));
    chk("async_reset_s_valid", 64'(s_valid), 64'(0));
    chk("async_reset_timeout", 64'(timeout), 64'(0));
    chk("async_reset_active_ch", 64'(active_ch), 64'(0));
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ultrasensor_multi_ctrl.md
ULTRASENSOR_MULTI_CTRL -- requirements
Module: ultrasensor_multi_ctrl

Interface
REQ-001 Parameter N_CH, default 4, number of sensor channels (1..8).
REQ-002 Parameter CNT_W, default 23, width of the cycle counter and each distance result.
REQ-003 Parameter TRIG_CYCLES, default 1000, trigger high time in clk cycles (10 us at 100 MHz).
REQ-004 Parameter MAX_CYCLES, default 1156852, maximum echo wait and echo width in cycles.
REQ-005 Parameter PERIOD_CYCLES, default 6000000, cycles from trigger rise to the next channel's trigger rise (60 ms).
REQ-006 clk  in  1  single system clock; all logic on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 control  in  1  run enable; low forces IDLE at the next clk edge.
REQ-009 ch_en  in  N_CH  per-channel enable mask, sampled when a channel is selected.
REQ-010 echo  in  N_CH  raw asynchronous echo lines, one per sensor.
REQ-011 trigger  out  N_CH  one-hot-or-zero trigger outputs.
REQ-012 s_echo  out  N_CH*CNT_W  per-channel echo width, channel k at bits [k*CNT_W +: CNT_W].
REQ-013 s_valid  out  N_CH  one-cycle pulse when channel k's s_echo updates.
REQ-014 timeout  out  N_CH  per-channel flag, set when the last measurement hit MAX_CYCLES.
REQ-015 active_ch  out  $clog2(N_CH) (min 1)  channel currently being measured.

Function
REQ-016 Each echo bit SHALL pass a 2-flop synchronizer; all decisions use the synchronized value.
REQ-017 States SHALL be IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
REQ-018 IDLE: with control high and ch_en nonzero, SHALL select the lowest enabled channel at or after active_ch (wrapping), clear the counter, enter TRIG.
REQ-019 TRIG: trigger[active_ch] SHALL be high exactly TRIG_CYCLES cycles, then WAIT_RISE.
REQ-020 WAIT_RISE: synchronized echo high SHALL clear the width counter and enter MEASURE; counter reaching MAX_CYCLES first SHALL record s_echo = MAX_CYCLES, set timeout, enter HOLDOFF.
REQ-021 MEASURE: width counter SHALL increment every cycle echo is high; echo low SHALL store the count, clear timeout, enter HOLDOFF; count reaching MAX_CYCLES SHALL saturate, store MAX_CYCLES, set timeout, enter HOLDOFF.
REQ-022 s_valid[active_ch] SHALL pulse on the cycle after the store; other channels' s_echo and timeout SHALL hold.
REQ-023 HOLDOFF: when the period counter reaches PERIOD_CYCLES-1, SHALL advance active_ch to the next enabled channel (wrap N_CH-1 to 0) and enter TRIG; if ch_en is zero, enter IDLE.
REQ-024 Disabled channels SHALL be skipped; a single enabled channel SHALL be re-measured every PERIOD_CYCLES.
REQ-025 control low in any state SHALL drop all triggers next edge, abandon the measurement without updating s_echo, go to IDLE; stored results persist.
REQ-026 Counters SHALL never wrap; all comparisons unsigned CNT_W bits.

Reset
REQ-027 Reset SHALL immediately force IDLE, trigger=0, s_echo=0, s_valid=0, timeout=0, active_ch=0, synchronizers and counters cleared.
REQ-028 Reset mid-TRIG SHALL drop the trigger without waiting for a clock edge.

Configuration
REQ-029 With US_AVG2_EN defined, each stored s_echo SHALL be (previous + new) >> 1 using a CNT_W+1 sum, the first sample after reset stored unaveraged; timeout samples SHALL store MAX_CYCLES and reset averaging history.
REQ-030 Without US_AVG2_EN, s_echo SHALL be the raw latest measurement and no history registers exist.

Verification
REQ-031 N_CH=4, ch_en=4'b1111, echo[0] high 5000 cycles starting 200 cycles after trigger fall -> trigger[0] high 1000 cycles, s_echo[0]=5000, s_valid[0] one pulse, timeout[0]=0.
REQ-032 echo[1] never rises -> s_echo[1]=MAX_CYCLES, timeout[1]=1, next trigger[2] exactly PERIOD_CYCLES after trigger[1] rise.
REQ-033 ch_en=4'b1010 -> trigger sequence 1,3,1,3; channels 0 and 2 never triggered, outputs unchanged.
REQ-034 control dropped mid-MEASURE on channel 2 -> trigger and FSM to IDLE, s_echo[2] unchanged, no s_valid; control re-raised resumes at channel 2.
REQ-035 reset asserted mid-TRIG between clock edges -> trigger falls combinationally with reset, all outputs 0.
REQ-036 US_AVG2_EN defined, consecutive widths 4000 then 6001 on channel 0 -> s_echo[0]=4000 then 5000.
